bist_misr_ora: RTL

- Output response analyzer for the 1-bit full-adder BIST path.
- Consumes the CUT response datain = {cout, sum} for each test pattern the TPG presents.
- Compacts the responses in a 4-bit MISR and compares the final signature with a golden value.
- Reports pass/fail back to the BIST controller.
- Sits downstream of the CUT and is the reader of the pattern stream the TPG produces.

---
 rtl/bist_pkg.sv | 19 +
 rtl/misr_lfsr.sv | 37 +++
 rtl/bist_misr_ora.sv | 96 +++++++++
 3 files changed

// File: rtl/bist_pkg.sv
// Shared types and constants for the full-adder BIST output response analyzer.
package bist_pkg;

  localparam int unsigned MisrWidth   = 4;
  localparam int unsigned NumPatterns = 8;

  // Feedback taps at bits 3 and 2
  localparam logic [MisrWidth-1:0] MisrTaps  = 4'b1100;
  // Fault-free signature for patterns 000..111 ascending, seed 0000
  localparam logic [MisrWidth-1:0] GoldenSig = 4'b1010;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StCompare,
    StDone
  } state_e;

endpackage

// File: rtl/misr_lfsr.sv
// Multiple-input signature register: shift with tap feedback, response XORed into bits [1:0].
module misr_lfsr
  import bist_pkg::*;
#(
  parameter int unsigned        Width = MisrWidth,
  parameter logic [Width-1:0]   Taps  = MisrTaps
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       din,
  output logic [Width-1:0] sig
);

  logic [Width-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = {sig_q[Width-2:0], ^(sig_q & Taps)} ^ {{(Width-2){1'b0}}, din};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/bist_misr_ora.sv
// BIST output response analyzer: compacts CUT responses and flags signature mismatch.
module bist_misr_ora
  import bist_pkg::*;
#(
  parameter int unsigned        MISR_W       = MisrWidth,
  parameter int unsigned        NUM_PATTERNS = NumPatterns,
  parameter logic [MISR_W-1:0]  GOLDEN_SIG   = GoldenSig
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              testmode,
  input  logic              pat_valid,
  input  logic [1:0]        datain,
  output logic [MISR_W-1:0] dataout_ora,
  output logic [3:0]        pat_count,
  output logic              busy,
  output logic              done,
  output logic              fault_detected
);

  localparam logic [3:0] CntMax  = 4'(NUM_PATTERNS);
  localparam logic [3:0] CntLast = 4'(NUM_PATTERNS - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              fault_q, fault_d;
  logic              misr_clr, misr_en;
  logic [MISR_W-1:0] sig;

  misr_lfsr #(
    .Width (MISR_W)
  ) u_misr (
    .clock (clock),
    .reset (reset),
    .clr   (misr_clr),
    .en    (misr_en),
    .din   (datain),
    .sig   (sig)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // Abort (testmode low) wins over a simultaneous pattern strobe
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (testmode) state_d = StCollect;
      StCollect: begin
        if (!testmode) begin
          state_d = StIdle;
        end else if (pat_valid && (cnt_q == CntLast)) begin
          state_d = StCompare;
        end
      end
      StCompare: state_d = StDone;
      StDone:    if (!testmode) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    misr_clr = (state_q == StIdle) && testmode;
    misr_en  = (state_q == StCollect) && testmode && pat_valid;
    busy     = (state_q == StCollect);
    done     = (state_q == StDone);

    cnt_d = cnt_q;
    if (misr_clr) begin
      cnt_d = '0;
    end else if (misr_en && (cnt_q < CntMax)) begin
      cnt_d = cnt_q + 4'd1;
    end

    fault_d = fault_q;
    if (state_q == StCompare) begin
      fault_d = (sig != GOLDEN_SIG);
    end else if (state_q != StDone || !testmode) begin
      fault_d = 1'b0;
    end
  end

  assign dataout_ora    = sig;
  assign pat_count      = cnt_q;
  assign fault_detected = fault_q;

endmodule
